// File: rtl/dff_pipe_pkg.sv
// Shared constants for the dff family: default data width, default pipeline
// depth and the width of the pipeline occupancy count.
package dffx;

    localparam int dff_bits_count = 8;
    localparam int dff_pipe_depth = 3;

    // Bits needed to count 0..depth valid stages.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One elastic pipeline stage: a valid bit plus a data register.
// The stage accepts from upstream whenever it is empty or downstream takes its
// current word; data only loads on a valid word so bubbles do not toggle it.
module dff_pipe_stage
    import dffx::*;
#(
    parameter int               WIDTH       = dff_bits_count,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             up_ready,
    input  logic             down_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Ready to load when empty or when the current word leaves this cycle.
    assign up_ready = !valid | down_ready;

    // Stage registers: clear on reset/flush, otherwise load when ready.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid <= 1'b0;
            data  <= RESET_VALUE;
        end else if (up_ready) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/dff_pipe.sv
// DEPTH-stage registered pipeline with valid/ready backpressure, bubble
// collapse under stall, synchronous flush and a registered occupancy count.
//
// Handshake: a word moves across an interface at a rising edge exactly when
// valid and ready are both 1 in the cycle before that edge. Ready never
// depends on the same interface's valid; upstream may hold valid while
// ready is 0 and the held word is taken later, never dropped.
module dff_pipe
    import dffx::*;
#(
    parameter int               WIDTH       = dff_bits_count,
    parameter int               DEPTH       = dff_pipe_depth,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [occ_width(DEPTH)-1:0]   occupancy
);

    localparam int               OW        = occ_width(DEPTH);
    localparam logic [OW-1:0]    DEPTH_CNT = OW'(DEPTH);

    if (DEPTH < 1) begin : g_bad_depth
        $error("dff_pipe: DEPTH must be >= 1");
    end

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] stage_rdy;
    logic             in_xfer;
    logic             out_xfer;

    // Ready chain from the output back to stage 0: a stage can load when it
    // is empty or everything ahead of it can advance.
    always_comb begin
        logic r;
        r          = out_ready;
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            r      = !v[i] | r;
            rdy[i] = r;
        end
    end

    assign in_ready  = rdy[0] & !flush & !rst;
    assign in_xfer   = in_valid & in_ready;
    assign out_valid = v[DEPTH-1] & !flush;
    assign out_data  = d[DEPTH-1];
    assign out_xfer  = out_valid & out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_valid_i;
        logic [WIDTH-1:0] up_data_i;

        if (i == 0) begin : g_first
            assign up_valid_i = in_xfer;
            assign up_data_i  = in_data;
        end else begin : g_next
            assign up_valid_i = v[i-1];
            assign up_data_i  = d[i-1];
        end

        dff_pipe_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .clear      (flush),
            .up_valid   (up_valid_i),
            .up_data    (up_data_i),
            .up_ready   (stage_rdy[i]),
            .down_ready (rdy[i+1]),
            .valid      (v[i]),
            .data       (d[i])
        );
    end

    // Occupancy tracks accepted minus delivered words; simultaneous in/out cancels.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occupancy <= '0;
        end else if (in_xfer && !out_xfer) begin
            occupancy <= occupancy + OW'(1);
        end else if (!in_xfer && out_xfer) begin
            occupancy <= occupancy - OW'(1);
        end
    end

    // Structural invariants: count bounded by depth, stage readies match the chain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (occupancy <= DEPTH_CNT);
            assert (stage_rdy == rdy[DEPTH-1:0]);
        end
    end

endmodule
